// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external ALU between two requesters.
// Operands and opcode are registered toward the ALU; the result is held until acked.
module alu_share_arbiter #(
  parameter int unsigned W     = 2,
  parameter int unsigned OPW   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic             ack0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  input  logic             ack1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [W-1:0]     alu_y,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StExec,
    StResp
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_rr_ptr;
  logic [W-1:0]       r_alu_a;
  logic [W-1:0]       r_alu_b;
  logic [OPW-1:0]     r_alu_s;
  logic [W-1:0]       r_result;
  logic [CNT_W-1:0]   r_ops_done;

  logic               w_any_req;
  logic               w_winner;
  logic               w_ack_own;
  logic               w_start;
  logic               w_finish;

  assign w_any_req = req0 | req1;
  // Contention goes to rr_ptr; otherwise whichever single requester is active.
  assign w_winner  = (req0 & req1) ? r_rr_ptr : req1;
  assign w_ack_own = r_owner ? ack1 : ack0;
  assign w_start   = (r_state == StIdle) & w_any_req;
  assign w_finish  = (r_state == StResp) & w_ack_own;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_nxt = StLatch;
      StLatch: w_state_nxt = StExec;
      StExec:  w_state_nxt = StResp;
      StResp:  if (w_ack_own) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_s    <= '0;
      r_result   <= '0;
      r_ops_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_owner <= w_winner;
      end
      if (r_state == StLatch) begin
        r_alu_a <= r_owner ? a1  : a0;
        r_alu_b <= r_owner ? b1  : b0;
        r_alu_s <= r_owner ? op1 : op0;
      end
      if (r_state == StExec) begin
        r_result <= alu_y;
      end
      if (w_finish) begin
        r_rr_ptr   <= ~r_owner;
        r_ops_done <= r_ops_done + CNT_W'(1);
      end
    end
  end

  // Handshake outputs decode registered state only, so no input-to-output path exists.
  assign gnt0     = (r_state == StLatch) & ~r_owner;
  assign gnt1     = (r_state == StLatch) &  r_owner;
  assign done0    = (r_state == StResp)  & ~r_owner;
  assign done1    = (r_state == StResp)  &  r_owner;
  assign busy     = (r_state != StIdle);
  assign result   = r_result;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_s    = r_alu_s;
  assign ops_done = r_ops_done;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; a second instance uses CNT_W=2.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, ack0, req1, ack1;
  logic [1:0] op0, a0, b0, op1, a1, b1;
  logic [1:0] alu_y;

  logic       gnt0, gnt1, done0, done1, busy;
  logic [1:0] result, alu_a, alu_b, alu_s;
  logic [7:0] ops_done;

  logic       u2_gnt0, u2_gnt1, u2_done0, u2_done1, u2_busy;
  logic [1:0] u2_result, u2_alu_a, u2_alu_b, u2_alu_s;
  logic [1:0] u2_ops_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(2), .OPW(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .ops_done(ops_done)
  );

  alu_share_arbiter #(.W(2), .OPW(2), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .gnt0(u2_gnt0), .gnt1(u2_gnt1), .done0(u2_done0), .done1(u2_done1),
    .result(u2_result), .busy(u2_busy),
    .alu_a(u2_alu_a), .alu_b(u2_alu_b), .alu_s(u2_alu_s), .alu_y(alu_y),
    .ops_done(u2_ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_ops = 0;
  endtask

  // One full transaction from the IDLE sampling edge; caller sets req/op/a/b beforehand.
  task automatic run_op(input logic who, input logic [1:0] y);
    logic [1:0] ea, eb, es;
    ea = who ? a1  : a0;
    eb = who ? b1  : b0;
    es = who ? op1 : op0;
    tick();
    chk("latch_gnt0", gnt0, !who);
    chk("latch_gnt1", gnt1, who);
    chk("latch_busy", busy, 1);
    tick();
    chk("exec_gnt0", gnt0, 0);
    chk("exec_gnt1", gnt1, 0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_s", alu_s, es);
    alu_y = y;
    tick();
    chk("resp_done0", done0, !who);
    chk("resp_done1", done1, who);
    chk("resp_result", result, y);
    if (who) ack1 = 1'b1;
    else     ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    ack1 = 1'b0;
    exp_ops++;
    chk("end_done0", done0, 0);
    chk("end_done1", done1, 0);
    chk("end_busy", busy, 0);
    chk("end_ops", ops_done, exp_ops[7:0]);
    chk("end_ops_c2", u2_ops_done, exp_ops[1:0]);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; ack0 = 0; req1 = 0; ack1 = 0;
    op0 = 0; a0 = 0; b0 = 0; op1 = 0; a1 = 0; b1 = 0;
    alu_y = 0;
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_result", result, 0);
    chk("rst_ops", ops_done, 0);
    reset = 1'b0;

    // Basic single transaction for requester 0.
    op0 = 2'b01; a0 = 2'b10; b0 = 2'b01; req0 = 1'b1;
    run_op(1'b0, 2'b11);
    req0 = 1'b0;
    tick();
    chk("idle_keep_alu_a", alu_a, 2'b10);
    chk("idle_keep_result", result, 2'b11);

    // Both requesters held: strict alternation starting at requester 0.
    do_reset();
    op0 = 2'b00; a0 = 2'b01; b0 = 2'b01;
    op1 = 2'b01; a1 = 2'b10; b1 = 2'b11;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(logic'(i % 2), 2'(i));
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_ops4", ops_done, 4);

    // Owner 1 in RESP ignores ack0.
    op1 = 2'b10; a1 = 2'b11; b1 = 2'b10; req1 = 1'b1;
    tick();
    chk("t3_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    alu_y = 2'b01;
    tick();
    alu_y = 2'b10;
    ack0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_done1", done1, 1);
      chk("t3_hold_done0", done0, 0);
      chk("t3_hold_result", result, 2'b01);
    end
    ack0 = 1'b0;
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("t3_done1_clr", done1, 0);
    chk("t3_busy", busy, 0);
    chk("t3_ops", ops_done, 5);

    // req1 drops in LATCH and a1/b1 change in EXEC; registered operands must not move.
    op1 = 2'b11; a1 = 2'b01; b1 = 2'b11; req1 = 1'b1;
    tick();
    chk("t4_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    chk("t4_alu_a", alu_a, 2'b01);
    chk("t4_alu_b", alu_b, 2'b11);
    chk("t4_alu_s", alu_s, 2'b11);
    a1 = 2'b10; b1 = 2'b00; alu_y = 2'b10;
    tick();
    chk("t4_done1", done1, 1);
    chk("t4_alu_a_held", alu_a, 2'b01);
    chk("t4_alu_b_held", alu_b, 2'b11);
    chk("t4_result", result, 2'b10);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("t4_ops", ops_done, 6);

    // Asynchronous reset during EXEC.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    chk("t5_busy_exec", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_b", alu_b, 0);
    chk("t5_alu_s", alu_s, 0);
    chk("t5_result", result, 0);
    chk("t5_ops", ops_done, 0);
    chk("t5_done1", done1, 0);
    #1;
    reset = 1'b0;
    exp_ops = 0;
    op1 = 2'b10; a1 = 2'b01; b1 = 2'b10; req1 = 1'b1;
    run_op(1'b1, 2'b11);
    req1 = 1'b0;

    // Narrow counter wraps: 1,2,3,0,1 on the CNT_W=2 instance.
    do_reset();
    op0 = 2'b11; a0 = 2'b11; b0 = 2'b00; req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, 2'(i + 1));
    end
    req0 = 1'b0;
    chk("wrap_c2_final", u2_ops_done, 1);
    chk("wrap_c8_final", ops_done, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
